prime_checker_axil_slave: RTL
=============================

# prime_checker_axil_slave

AXI4-Lite slave answering the master VIP / PS master in the prime checker block design. It exposes a four-register map (control, number, status, factor) and runs a sequential odd-trial-division primality test on a 32-bit operand. For composite inputs it reports the smallest divisor. It is the responder end of the AXI4-Lite bus that the block-design testbench drives.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; four 32-bit registers
- ACLK  in  1  the only clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream
- S_AXI_AWADDR/AWPROT/AWVALID  in  4/3/1  write address channel; AWPROT ignored
- S_AXI_AWREADY  out  1  write address accept
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel
- S_AXI_WREADY  out  1  write data accept
- S_AXI_BRESP/BVALID  out  2/1  write response; BRESP always 2'b00
- S_AXI_BREADY  in  1
- S_AXI_ARADDR/ARPROT/ARVALID  in  4/3/1  read address channel
- S_AXI_ARREADY  out  1
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data; RRESP always 2'b00
- S_AXI_RREADY  in  1
- irq  out  1  present only with PRIME_CHECKER_IRQ_EN

## Operation
- Register map, decoded on address bits [3:2]:
  - 0x0 CTRL. Bit0 START: write 1 starts a test; self-clearing; reads 0. Bit1 IE.
  - 0x4 NUMBER. R/W operand n.
  - 0x8 STATUS. Bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 PRIME (RO).
  - 0xC FACTOR. RO smallest divisor; 0 when n is prime or n<2.
- WSTRB is honoured per byte on CTRL and NUMBER. Writes to RO bits and to FACTOR are ignored, with OKAY response.
- Writes to NUMBER or CTRL.START while BUSY are ignored. The running test is unaffected.
- START with BUSY=0 does the following on the same edge: latches n, clears DONE/PRIME/FACTOR, sets BUSY, and moves the FSM from IDLE.
- FSM states:
  - IDLE
  - CLASSIFY
    - n<2: not prime, FACTOR=0.
    - n==2 or 3: prime.
    - n even: FACTOR=2.
    - Otherwise: d=3, sq=9, go to TEST.
  - TEST
    - sq>n: prime, finish.
    - Otherwise: go to DIV.
  - DIV
    - Restoring division n/d, exactly 32 cycles.
    - Remainder 0: FACTOR=d, finish.
    - Otherwise: sq += 4d+4, d += 2, go to TEST.
  - Finish sets DONE, clears BUSY, returns to IDLE.
- Width rules:
  - d is 32 bits.
  - sq is 64 bits, so the compare never wraps.
  - Remainder register is 33 bits.

## Timing
- Reset: all outputs 0. All registers 0. FSM in IDLE.
- ARESETN low mid-test aborts the test immediately. Nothing is retained.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle, in the cycle after AWVALID&WVALID are both seen with BVALID=0.
  - Register update occurs on that handshake edge.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID=1.
- Read channel:
  - ARREADY pulses one cycle after ARVALID while RVALID=0.
  - RVALID and RDATA follow the next cycle. RDATA holds stable until RREADY.
- Simultaneous read and write are independent. A read returns the value before any same-edge update.
- Compute latency after START, counting BUSY-high cycles:
  - Trivial/even cases: 1.
  - Otherwise: 1 + k·33 + (1 if prime), where k = number of odd divisors tried.
- DONE W1C on the same edge as finish: finish wins, DONE=1.

## Configuration
- PRIME_CHECKER_IRQ_EN defined:
  - Port irq = DONE & IE, registered.
  - irq asserts one cycle after DONE sets and deasserts one cycle after the W1C.
- PRIME_CHECKER_IRQ_EN undefined:
  - No irq port.
  - CTRL bit1 reads 0 and ignores writes.

## Test plan
- Reset release → all four registers read 0x0000_0000, all outputs 0; BVALID/RVALID never assert without a request.
- NUMBER=97, CTRL=1, poll STATUS → BUSY seen, then STATUS=0x6, FACTOR=0; BUSY-high cycles = 1+4·33+1 = 134.
- NUMBER=91 → STATUS=0x2, FACTOR=7. NUMBER=0xFFFF_FFFF → FACTOR=3. NUMBER=65521 → STATUS=0x6.
- NUMBER=0 → STATUS=0x2, FACTOR=0. NUMBER=1 → STATUS=0x2, FACTOR=0. NUMBER=2 → STATUS=0x6. NUMBER=4 → FACTOR=2. Each case has 1 BUSY cycle.
- During a BUSY test on 65521:
  - Write NUMBER=10 and CTRL=1 → both get OKAY, NUMBER still reads 65521, result unchanged.
  - Then write STATUS=0x2 → DONE clears.
- ARESETN pulse low mid-DIV → all registers 0 and FSM in IDLE. With IRQ_EN and IE=1, irq rises after DONE and falls after the W1C.

Source files
------------

// File: rtl/prime_checker_axil_slave_if.sv
// AXI4-Lite bus bundle for the prime checker slave. The master modport is the bus driver
// and the slave modport is the register block.
interface prime_checker_axil_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/prime_checker_axil_slave.sv
// AXI4-Lite slave with CTRL/NUMBER/STATUS/FACTOR registers driving an odd-trial-division
// primality tester. Define PRIME_CHECKER_IRQ_EN to add the CTRL.IE bit and the irq output.
module prime_checker_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    prime_checker_axil_slave_if.slave s_axi
`ifdef PRIME_CHECKER_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic [1:0] {REG_CTRL, REG_NUMBER, REG_STATUS, REG_FACTOR} reg_sel_e;
    typedef enum logic [1:0] {IDLE, CLASSIFY, TEST, DIV} state_e;

    state_e                        state_q, state_d;
    logic [DW-1:0]                 number_q, n_q, factor_q;
    logic [DW-1:0]                 d_q, d_d, dvd_q, dvd_d;
    logic [63:0]                   sq_q, sq_d;
    logic [32:0]                   rem_q, rem_d, rem_shift, rem_step;
    logic [4:0]                    cnt_q, cnt_d;
    logic                          done_q, prime_q, ie, busy;
    logic                          wr_en, rd_en, start, done_w1c;
    logic                          fin, fin_prime;
    logic [DW-1:0]                 fin_factor, rd_mux;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    reg_sel_e                      wr_sel, rd_sel;

    assign wr_addr = s_axi.awaddr;
    assign rd_addr = s_axi.araddr;
    assign wr_sel  = reg_sel_e'(wr_addr[3:2]);
    assign rd_sel  = reg_sel_e'(rd_addr[3:2]);

    assign wr_en    = s_axi.awready & s_axi.awvalid & s_axi.wready & s_axi.wvalid;
    assign rd_en    = s_axi.arready & s_axi.arvalid;
    assign busy     = (state_q != IDLE);
    assign start    = wr_en && (wr_sel == REG_CTRL) && s_axi.wstrb[0] && s_axi.wdata[0] && !busy;
    assign done_w1c = wr_en && (wr_sel == REG_STATUS) && s_axi.wstrb[0] && s_axi.wdata[1];

    assign s_axi.bresp = 2'b00;
    assign s_axi.rresp = 2'b00;

    // Byte offsets, protection bits and the always-zero remainder MSB carry no information.
    logic unused_ok;
    assign unused_ok = ^{wr_addr[1:0], rd_addr[1:0], s_axi.awprot, s_axi.arprot, rem_q[32]};

    // Write channel: accept address and data together, then hold the response until taken.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b0;
            s_axi.bvalid  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples
            // pre-edge values; blocking here would make ordering between blocks matter.
            if (!s_axi.awready && s_axi.awvalid && s_axi.wvalid && !s_axi.bvalid) begin
                s_axi.awready <= 1'b1;
                s_axi.wready  <= 1'b1;
            end else begin
                s_axi.awready <= 1'b0;
                s_axi.wready  <= 1'b0;
            end
            if (wr_en)
                s_axi.bvalid <= 1'b1;
            else if (s_axi.bready)
                s_axi.bvalid <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            REG_CTRL:   rd_mux[1]   = ie;
            REG_NUMBER: rd_mux      = number_q;
            REG_STATUS: rd_mux[2:0] = {prime_q, done_q, busy};
            REG_FACTOR: rd_mux      = factor_q;
            default:    rd_mux      = '0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b0;
            s_axi.rdata   <= '0;
        end else begin
            s_axi.arready <= !s_axi.arready && s_axi.arvalid && !s_axi.rvalid;
            if (rd_en) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata  <= rd_mux;
            end else if (s_axi.rready) begin
                s_axi.rvalid <= 1'b0;
            end
        end
    end

    // Register file; a finishing test takes priority over a same-edge DONE clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            number_q <= '0;
            n_q      <= '0;
            done_q   <= 1'b0;
            prime_q  <= 1'b0;
            factor_q <= '0;
        end else begin
            if (wr_en && (wr_sel == REG_NUMBER) && !busy) begin
                for (int i = 0; i < DW/8; i++)
                    if (s_axi.wstrb[i]) number_q[8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
            if (start) begin
                n_q      <= number_q;
                done_q   <= 1'b0;
                prime_q  <= 1'b0;
                factor_q <= '0;
            end else if (fin) begin
                done_q   <= 1'b1;
                prime_q  <= fin_prime;
                factor_q <= fin_factor;
            end else if (done_w1c) begin
                done_q   <= 1'b0;
            end
        end
    end

`ifdef PRIME_CHECKER_IRQ_EN
    logic ie_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ie_q <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && (wr_sel == REG_CTRL) && s_axi.wstrb[0]) ie_q <= s_axi.wdata[1];
            irq <= done_q & ie_q;
        end
    end

    assign ie = ie_q;
`else
    assign ie = 1'b0;
`endif

    // One restoring-division step: shift in the next dividend bit, subtract d if it fits.
    assign rem_shift = {rem_q[31:0], dvd_q[DW-1]};
    assign rem_step  = (rem_shift >= {1'b0, d_q}) ? rem_shift - {1'b0, d_q} : rem_shift;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            d_q     <= '0;
            sq_q    <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            sq_q    <= sq_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d    = state_q;
        d_d        = d_q;
        sq_d       = sq_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        cnt_d      = cnt_q;
        fin        = 1'b0;
        fin_prime  = 1'b0;
        fin_factor = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLASSIFY;
            end
            CLASSIFY: begin
                if (n_q < 32'd2) begin
                    fin = 1'b1;
                end else if (n_q == 32'd2 || n_q == 32'd3) begin
                    fin       = 1'b1;
                    fin_prime = 1'b1;
                end else if (!n_q[0]) begin
                    fin        = 1'b1;
                    fin_factor = 32'd2;
                end else begin
                    d_d     = 32'd3;
                    sq_d    = 64'd9;
                    state_d = TEST;
                end
                if (fin) state_d = IDLE;
            end
            TEST: begin
                if (sq_q > 64'(n_q)) begin
                    fin       = 1'b1;
                    fin_prime = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rem_d   = '0;
                    dvd_d   = n_q;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = rem_step;
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (rem_step == 33'd0) begin
                        fin        = 1'b1;
                        fin_factor = d_q;
                        state_d    = IDLE;
                    end else begin
                        // (d+2)^2 = d^2 + 4d + 4
                        sq_d    = sq_q + 64'({d_q, 2'b00}) + 64'd4;
                        d_d     = d_q + 32'd2;
                        state_d = TEST;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
